// File: rtl/mc_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control unit for the 16-bit windowed-register CPU.
// Optional retired-instruction counter enabled by defining MC_CTRL_INSTRET_EN.
module mc_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] inst,
    input  logic        zero,
    output logic        ldw,
    output logic        wdsel,
    output logic        regwrite,
    output logic        pc1sel,
    output logic        pc2sel,
    output logic        asel,
    output logic        memread,
    output logic        memwrite,
    output logic        memtoreg,
    output logic [2:0]  aluop,
    output logic        pcwrite,
    output logic        halted,
    output logic [15:0] instret
);
    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    typedef struct packed {
        logic       ldw;
        logic       wdsel;
        logic       regwrite;
        logic       pc1sel;
        logic       pc2sel;
        logic       asel;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic [2:0] aluop;
        logic       pcwrite;
        logic       halted;
    } ctrl_t;

    typedef struct packed {
        logic load, store, jump, wndw, brz, halt, move, alu_r, alu_i;
    } cls_t;

    function automatic cls_t classify(input logic [15:0] i);
        cls_t k;
        k        = '0;
        k.load   = (i[15:12] == 4'b0000);
        k.store  = (i[15:12] == 4'b0001);
        k.jump   = (i[15:12] == 4'b0010);
        k.wndw   = (i[15:12] == 4'b0011);
        k.brz    = (i[15:12] == 4'b0100);
        k.halt   = (i[15:12] == 4'b0111);
        k.move   = (i[15:12] == 4'b1000) && (i[3:0] == 4'd0);
        k.alu_r  = (i[15:12] == 4'b1000) && (i[3:0] >= 4'd1) && (i[3:0] <= 4'd5);
        k.alu_i  = (i[15:14] == 2'b11);
        return k;
    endfunction

    // Control word for a given state; evaluated on next-state values so outputs are registered yet Moore.
    function automatic ctrl_t ctrl_for(input state_t s, input logic [15:0] i, input logic z);
        ctrl_t      c;
        cls_t       k;
        logic [3:0] func_m1;
        logic [2:0] op_v;
        logic       is_alu;
        c       = '0;
        k       = classify(i);
        func_m1 = i[3:0] - 4'd1;
        op_v    = k.alu_i ? {1'b0, i[13:12]} : func_m1[2:0];
        is_alu  = k.alu_r || k.alu_i;
        case (s)
            S_DECODE: begin
                if (k.jump) begin
                    c.pc2sel  = 1'b1;
                    c.pcwrite = 1'b1;
                end else if (k.brz) begin
                    c.pc1sel  = z;
                    c.pcwrite = 1'b1;
                end else if (!(is_alu || k.move || k.load || k.store || k.wndw || k.halt)) begin
                    c.pcwrite = 1'b1;
                end
            end
            S_EXEC: begin
                if (is_alu) begin
                    c.aluop = op_v;
                    c.asel  = k.alu_i;
                end else if (k.wndw) begin
                    c.ldw     = 1'b1;
                    c.pcwrite = 1'b1;
                end
            end
            S_MEM: begin
                if (k.load) begin
                    c.memread = 1'b1;
                end else if (k.store) begin
                    c.memwrite = 1'b1;
                    c.pcwrite  = 1'b1;
                end
            end
            S_WB: begin
                c.regwrite = 1'b1;
                c.pcwrite  = 1'b1;
                if (is_alu) begin
                    c.aluop = op_v;
                    c.asel  = k.alu_i;
                    c.wdsel = 1'b1;
                end else if (k.load) begin
                    c.memread  = 1'b1;
                    c.memtoreg = 1'b1;
                    c.wdsel    = 1'b1;
                end
            end
            S_HALT:  c.halted = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t      state_reg, state_next;
    logic [15:0] ir_reg, ir_next;
    logic        zf_reg, zf_next;
    ctrl_t       ctrl_reg;
    cls_t        cls;
    logic        unused_ir_bits;

    assign cls            = classify(ir_reg);
    assign unused_ir_bits = ^ir_reg[11:4];

    always_comb begin
        state_next = state_reg;
        ir_next    = ir_reg;
        zf_next    = zf_reg;
        case (state_reg)
            S_FETCH: begin
                ir_next    = inst;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                if (cls.alu_r || cls.alu_i || cls.wndw) state_next = S_EXEC;
                else if (cls.move)                      state_next = S_WB;
                else if (cls.load || cls.store)         state_next = S_MEM;
                else if (cls.halt)                      state_next = S_HALT;
                else                                    state_next = S_FETCH;
            end
            S_EXEC: begin
                if (cls.alu_r || cls.alu_i) begin
                    zf_next    = zero;
                    state_next = S_WB;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_MEM:   state_next = cls.load ? S_WB : S_FETCH;
            S_WB:    state_next = S_FETCH;
            S_HALT:  state_next = S_HALT;
            default: state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_FETCH;
            ir_reg    <= '0;
            zf_reg    <= 1'b0;
            ctrl_reg  <= '0;
        end else begin
            state_reg <= state_next;
            ir_reg    <= ir_next;
            zf_reg    <= zf_next;
            ctrl_reg  <= ctrl_for(state_next, ir_next, zf_next);
        end
    end

`ifdef MC_CTRL_INSTRET_EN
    logic [15:0] instret_reg;
    always_ff @(posedge clk) begin
        if (rst)                   instret_reg <= '0;
        else if (ctrl_reg.pcwrite) instret_reg <= instret_reg + 16'd1;
    end
    assign instret = instret_reg;
`else
    assign instret = 16'h0000;
`endif

    assign ldw      = ctrl_reg.ldw;
    assign wdsel    = ctrl_reg.wdsel;
    assign regwrite = ctrl_reg.regwrite;
    assign pc1sel   = ctrl_reg.pc1sel;
    assign pc2sel   = ctrl_reg.pc2sel;
    assign asel     = ctrl_reg.asel;
    assign memread  = ctrl_reg.memread;
    assign memwrite = ctrl_reg.memwrite;
    assign memtoreg = ctrl_reg.memtoreg;
    assign aluop    = ctrl_reg.aluop;
    assign pcwrite  = ctrl_reg.pcwrite;
    assign halted   = ctrl_reg.halted;
endmodule
